// File: rtl/uart_frame_rx_param.sv
// uart_frame_rx_param: 8N1 byte receiver plus fixed-length frame parser.
// A frame is HEADER, PAYLOAD_LEN payload bytes, CRC8, TAIL. A good frame
// updates payload_data and pulses frame_valid. Every abort or bad frame
// writes a status code and bumps a saturating error counter.
`timescale 1ns/1ps
module uart_frame_rx_param #(
    parameter int          CLK_FREQ     = 50_000_000,
    parameter int          UART_BPS     = 115200,
    parameter int          PAYLOAD_LEN  = 11,
    parameter logic [7:0]  HEADER       = 8'h55,
    parameter logic [7:0]  TAIL         = 8'hAA,
    parameter logic [7:0]  CRC_POLY     = 8'h07,
    parameter logic [7:0]  CRC_INIT     = 8'h00,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     uart_rxd,
    output logic [7:0]               byte_data,
    output logic                     byte_valid,
    output logic                     frame_busy,
    output logic [8*PAYLOAD_LEN-1:0] payload_data,
    output logic                     frame_valid,
    output logic [7:0]               status,
    output logic [15:0]              err_cnt
);

    localparam int BPS_CNT   = CLK_FREQ / UART_BPS;
    localparam int HALF_CNT  = BPS_CNT / 2;
    localparam int CW        = $clog2(BPS_CNT + 1);
    localparam int PW        = 8 * PAYLOAD_LEN;
    localparam int IW        = $clog2(PAYLOAD_LEN + 1);
    localparam int TMO_LIMIT = TIMEOUT_BITS * BPS_CNT;
    localparam int TW        = $clog2(TMO_LIMIT + 1);

    localparam logic [7:0] ST_GOOD    = 8'h01;
    localparam logic [7:0] ST_BADTAIL = 8'h02;
    localparam logic [7:0] ST_TIMEOUT = 8'h03;
    localparam logic [7:0] ST_BADCRC  = 8'h04;
    localparam logic [7:0] ST_FRAMING = 8'h05;

    typedef enum logic [1:0] {BYTE_IDLE, BYTE_START, BYTE_DATA, BYTE_STOP} byte_state_t;
    typedef enum logic [1:0] {HUNT, PAYLOAD, CRC, TAIL_ST} frame_state_t;

    byte_state_t  byte_state;
    frame_state_t frame_state;

    logic [2:0]    rxd_sync;
    logic          rx_bit;
    logic          rx_fall;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          frame_err;

    logic [7:0]    crc;
    logic          crc_bad;
    logic [IW-1:0] idx;
    logic [TW-1:0] tmo_cnt;
    logic [PW-1:0] payload_buf;

    // One step of MSB-first CRC8: fold in a whole byte, then shift 8 times.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    // Error counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign rx_bit  = rxd_sync[1];
    assign rx_fall = rxd_sync[2] & ~rxd_sync[1];

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            rxd_sync <= 3'b111;
        end else begin
            rxd_sync <= {rxd_sync[1:0], uart_rxd};
        end
    end

    // Byte receiver: mid-bit sampling, glitch rejection and stop-bit check.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            byte_state <= BYTE_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (byte_state)
                BYTE_IDLE: begin
                    bit_cnt <= '0;
                    if (rx_fall) begin
                        byte_state <= BYTE_START;
                    end
                end
                BYTE_START: begin
                    if (bit_cnt == CW'(HALF_CNT) && rx_bit) begin
                        byte_state <= BYTE_IDLE;
                        bit_cnt    <= '0;
                    end else if (bit_cnt == CW'(BPS_CNT - 1)) begin
                        byte_state <= BYTE_DATA;
                        bit_cnt    <= '0;
                        bit_idx    <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                BYTE_DATA: begin
                    if (bit_cnt == CW'(HALF_CNT)) begin
                        shift_reg <= {rx_bit, shift_reg[7:1]};
                    end
                    if (bit_cnt == CW'(BPS_CNT - 1)) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            byte_state <= BYTE_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                BYTE_STOP: begin
                    if (bit_cnt == CW'(HALF_CNT)) begin
                        if (rx_bit) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift_reg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        byte_state <= BYTE_IDLE;
                        bit_cnt    <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: byte_state <= BYTE_IDLE;
            endcase
        end
    end

    // Frame parser: header hunt, payload/CRC collection, tail check,
    // inter-byte timeout and framing-error aborts. A received byte always
    // takes priority over a timeout expiring in the same cycle.
    // tmo_cnt holds the number of cycles elapsed since the last byte strobe,
    // so the abort fires on the edge where that count reaches TMO_LIMIT.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            frame_state  <= HUNT;
            crc          <= '0;
            crc_bad      <= 1'b0;
            idx          <= '0;
            tmo_cnt      <= '0;
            payload_buf  <= '0;
            payload_data <= '0;
            frame_valid  <= 1'b0;
            frame_busy   <= 1'b0;
            status       <= '0;
            err_cnt      <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (frame_state == HUNT) begin
                tmo_cnt <= '0;
                if (byte_valid && byte_data == HEADER) begin
                    crc         <= CRC_INIT;
                    idx         <= '0;
                    frame_busy  <= 1'b1;
                    tmo_cnt     <= TW'(1);
                    frame_state <= PAYLOAD;
                end
            end else if (byte_valid) begin
                tmo_cnt <= TW'(1);
                case (frame_state)
                    PAYLOAD: begin
                        payload_buf <= PW'({byte_data, payload_buf} >> 8);
                        crc         <= crc8_next(crc, byte_data);
                        if (idx == IW'(PAYLOAD_LEN - 1)) begin
                            frame_state <= CRC;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    CRC: begin
                        crc_bad     <= (byte_data != crc);
                        frame_state <= TAIL_ST;
                    end
                    TAIL_ST: begin
                        tmo_cnt     <= '0;
                        frame_busy  <= 1'b0;
                        frame_state <= HUNT;
                        if (byte_data != TAIL) begin
                            status  <= ST_BADTAIL;
                            err_cnt <= sat_inc(err_cnt);
                        end else if (crc_bad) begin
                            status  <= ST_BADCRC;
                            err_cnt <= sat_inc(err_cnt);
                        end else begin
                            status       <= ST_GOOD;
                            payload_data <= payload_buf;
                            frame_valid  <= 1'b1;
                        end
                    end
                    default: frame_state <= HUNT;
                endcase
            end else if (frame_err) begin
                tmo_cnt     <= '0;
                frame_busy  <= 1'b0;
                frame_state <= HUNT;
                status      <= ST_FRAMING;
                err_cnt     <= sat_inc(err_cnt);
            end else if (tmo_cnt == TW'(TMO_LIMIT - 1)) begin
                tmo_cnt     <= '0;
                frame_busy  <= 1'b0;
                frame_state <= HUNT;
                status      <= ST_TIMEOUT;
                err_cnt     <= sat_inc(err_cnt);
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx_param.sv
// Testbench for uart_frame_rx_param: table-driven frames, hand-written
// corner sequences and a randomized phase against a byte-level frame model.
`timescale 1ns/1ps
module tb_uart_frame_rx_param;

    localparam int         BIT_CYC = 10;
    localparam int         L       = 2;
    localparam logic [7:0] HDR     = 8'h55;
    localparam logic [7:0] TL      = 8'hAA;

    logic          sys_clk;
    logic          sys_rst_n;
    logic          uart_rxd;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          frame_busy;
    logic [8*L-1:0] payload_data;
    logic          frame_valid;
    logic [7:0]    status;
    logic [15:0]   err_cnt;

    int tests_run;
    int tests_failed;
    int cycle;
    int bv_count;
    int fv_count;
    int last_bv_cycle;

    uart_frame_rx_param #(
        .CLK_FREQ(1_000_000),
        .UART_BPS(100_000),
        .PAYLOAD_LEN(L),
        .HEADER(HDR),
        .TAIL(TL),
        .CRC_POLY(8'h07),
        .CRC_INIT(8'h00),
        .TIMEOUT_BITS(20)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .uart_rxd(uart_rxd),
        .byte_data(byte_data),
        .byte_valid(byte_valid),
        .frame_busy(frame_busy),
        .payload_data(payload_data),
        .frame_valid(frame_valid),
        .status(status),
        .err_cnt(err_cnt)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Cycle counter used to measure latencies.
    always @(posedge sys_clk) begin
        cycle++;
    end

    // Strobe monitor, sampling away from the active edge.
    always @(negedge sys_clk) begin
        if (byte_valid) begin
            bv_count++;
            last_bv_cycle = cycle;
        end
        if (frame_valid) begin
            fv_count++;
        end
    end

    // Overall time limit so the run can never hang.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- behavioural frame model ----------------
    logic [7:0]  mq[$];
    bit          m_busy;
    logic [7:0]  m_status;
    logic [15:0] m_err;
    logic [15:0] m_payload;
    int          m_fv;

    // CRC as the remainder of (message * x^8) divided by x^8+x^2+x+1.
    function automatic logic [7:0] crcRef(input logic [15:0] msg);
        logic [23:0] m;
        logic [8:0]  r;
        m = {msg, 8'h00};
        r = '0;
        for (int i = 23; i >= 0; i--) begin
            r = {r[7:0], m[i]};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic void modelBad(input logic [7:0] code);
        m_status = code;
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        m_busy = 0;
    endfunction

    function automatic void modelByte(input logic [7:0] b);
        if (!m_busy) begin
            if (b == HDR) begin
                m_busy = 1;
                mq.delete();
            end
            return;
        end
        mq.push_back(b);
        if (mq.size() == L + 2) begin
            if (mq[L+1] != TL) modelBad(8'h02);
            else if (mq[L] != crcRef({mq[0], mq[1]})) modelBad(8'h04);
            else begin
                m_status  = 8'h01;
                m_payload = {mq[1], mq[0]};
                m_fv++;
                m_busy = 0;
            end
        end
    endfunction

    function automatic void modelAbort(input logic [7:0] code);
        if (m_busy) modelBad(code);
    endfunction

    // ---------------- helper tasks ----------------
    task automatic waitCycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Serialise one 8N1 byte; stop_ok=0 forces a framing error.
    task automatic applyStimulus(input logic [7:0] b, input bit stop_ok);
        uart_rxd = 1'b0;
        waitCycles(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            waitCycles(BIT_CYC);
        end
        uart_rxd = stop_ok;
        waitCycles(BIT_CYC);
        uart_rxd = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sendGoodFrame();
        applyStimulus(HDR, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h1B, 1'b1);
        applyStimulus(TL, 1'b1);
        waitCycles(15);
    endtask

    // ---------------- table ----------------
    typedef struct {
        string       name;
        logic [39:0] bytes;
        logic [7:0]  exp_status;
        logic [15:0] exp_payload;
        logic [15:0] exp_err;
        int          exp_fv;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int fv0;
        int bv0;
        int found;
        int seen_cycle;
        logic [7:0] p0, p1, c, t, g;
        int kind;

        tests_run = 0; tests_failed = 0; cycle = 0;
        bv_count = 0; fv_count = 0; last_bv_cycle = 0;

        vecs[0] = '{"good_frame", 40'h55_01_02_1B_AA, 8'h01, 16'h0201, 16'd0, 1};
        vecs[1] = '{"bad_crc",    40'h55_01_02_06_AA, 8'h04, 16'h0201, 16'd1, 0};
        vecs[2] = '{"bad_tail",   40'h55_01_02_1B_00, 8'h02, 16'h0201, 16'd2, 0};

        uart_rxd  = 1'b1;
        sys_rst_n = 1'b1;
        waitCycles(3);
        sys_rst_n = 1'b0;
        waitCycles(3);

        checkOutput("rst_byte_data", {24'd0, byte_data}, 32'h0);
        checkOutput("rst_byte_valid", {31'd0, byte_valid}, 32'h0);
        checkOutput("rst_frame_valid", {31'd0, frame_valid}, 32'h0);
        checkOutput("rst_frame_busy", {31'd0, frame_busy}, 32'h0);
        checkOutput("rst_payload", {16'd0, payload_data}, 32'h0);
        checkOutput("rst_status", {24'd0, status}, 32'h0);
        checkOutput("rst_err_cnt", {16'd0, err_cnt}, 32'h0);

        // Table-driven back-to-back frames.
        for (int v = 0; v < 3; v++) begin
            fv0 = fv_count;
            for (int k = 0; k < 5; k++) begin
                applyStimulus(vecs[v].bytes[39-8*k -: 8], 1'b1);
            end
            waitCycles(15);
            checkOutput({vecs[v].name, "_status"}, {24'd0, status}, {24'd0, vecs[v].exp_status});
            checkOutput({vecs[v].name, "_payload"}, {16'd0, payload_data}, {16'd0, vecs[v].exp_payload});
            checkOutput({vecs[v].name, "_err"}, {16'd0, err_cnt}, {16'd0, vecs[v].exp_err});
            checkOutput({vecs[v].name, "_fv"}, fv_count - fv0, vecs[v].exp_fv);
            checkOutput({vecs[v].name, "_byte"}, {24'd0, byte_data}, {24'd0, vecs[v].bytes[7:0]});
        end

        // Leading garbage is discarded, then a good frame is accepted.
        fv0 = fv_count;
        applyStimulus(8'h12, 1'b1);
        applyStimulus(8'h34, 1'b1);
        waitCycles(5);
        checkOutput("garbage_busy", {31'd0, frame_busy}, 32'h0);
        applyStimulus(HDR, 1'b1);
        waitCycles(2);
        checkOutput("header_busy", {31'd0, frame_busy}, 32'h1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h1B, 1'b1);
        applyStimulus(TL, 1'b1);
        waitCycles(15);
        checkOutput("garbage_status", {24'd0, status}, 32'h01);
        checkOutput("garbage_err", {16'd0, err_cnt}, 32'd2);
        checkOutput("garbage_fv", fv_count - fv0, 1);

        // Inter-byte timeout: status must change 200 cycles after the strobe.
        applyStimulus(HDR, 1'b1);
        applyStimulus(8'h01, 1'b1);
        found = 0;
        seen_cycle = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge sys_clk);
            if (status == 8'h03) begin
                found = 1;
                seen_cycle = cycle;
            end
        end
        checkOutput("timeout_seen", found, 1);
        checkOutput("timeout_latency", seen_cycle - last_bv_cycle, 200);
        checkOutput("timeout_busy", {31'd0, frame_busy}, 32'h0);
        checkOutput("timeout_err", {16'd0, err_cnt}, 32'd3);
        waitCycles(50);

        // A short low glitch on an idle line produces no byte.
        bv0 = bv_count;
        uart_rxd = 1'b0;
        waitCycles(3);
        uart_rxd = 1'b1;
        waitCycles(30);
        checkOutput("glitch_no_byte", bv_count - bv0, 0);
        checkOutput("glitch_status", {24'd0, status}, 32'h03);

        // Stop bit forced low inside a frame.
        bv0 = bv_count;
        applyStimulus(HDR, 1'b1);
        applyStimulus(8'h01, 1'b0);
        waitCycles(15);
        checkOutput("framing_status", {24'd0, status}, 32'h05);
        checkOutput("framing_busy", {31'd0, frame_busy}, 32'h0);
        checkOutput("framing_err", {16'd0, err_cnt}, 32'd4);
        checkOutput("framing_bytes", bv_count - bv0, 1);

        // Reset mid-frame, then a good frame.
        applyStimulus(HDR, 1'b1);
        applyStimulus(8'h01, 1'b1);
        waitCycles(2);
        checkOutput("midframe_busy", {31'd0, frame_busy}, 32'h1);
        sys_rst_n = 1'b1;
        waitCycles(2);
        checkOutput("midrst_status", {24'd0, status}, 32'h0);
        checkOutput("midrst_err", {16'd0, err_cnt}, 32'h0);
        checkOutput("midrst_payload", {16'd0, payload_data}, 32'h0);
        checkOutput("midrst_busy", {31'd0, frame_busy}, 32'h0);
        checkOutput("midrst_byte", {24'd0, byte_data}, 32'h0);
        sys_rst_n = 1'b0;
        waitCycles(5);
        fv0 = fv_count;
        sendGoodFrame();
        checkOutput("postrst_status", {24'd0, status}, 32'h01);
        checkOutput("postrst_payload", {16'd0, payload_data}, 32'h0201);
        checkOutput("postrst_err", {16'd0, err_cnt}, 32'h0);
        checkOutput("postrst_fv", fv_count - fv0, 1);

        // Randomized frames against the model, starting from reset.
        sys_rst_n = 1'b1;
        waitCycles(2);
        sys_rst_n = 1'b0;
        waitCycles(5);
        mq.delete();
        m_busy = 0; m_status = 8'h00; m_err = 16'd0; m_payload = 16'd0; m_fv = 0;
        fv0 = fv_count;
        for (int f = 0; f < 14; f++) begin
            kind = $urandom_range(0, 4);
            p0 = 8'($urandom);
            p1 = 8'($urandom);
            c  = crcRef({p0, p1});
            t  = TL;
            if (kind == 1) c = c ^ 8'($urandom_range(1, 255));
            if (kind == 2) t = TL ^ 8'($urandom_range(1, 255));
            if (kind == 3) begin
                g = 8'($urandom);
                if (g == HDR) g = 8'h00;
                applyStimulus(g, 1'b1);
                modelByte(g);
            end
            if (kind == 4) begin
                applyStimulus(HDR, 1'b1);
                modelByte(HDR);
                for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                    applyStimulus(p0, 1'b1);
                    modelByte(p0);
                end
                waitCycles(250);
                modelAbort(8'h03);
            end else begin
                applyStimulus(HDR, 1'b1);
                modelByte(HDR);
                waitCycles($urandom_range(0, 30));
                applyStimulus(p0, 1'b1);
                modelByte(p0);
                waitCycles($urandom_range(0, 30));
                applyStimulus(p1, 1'b1);
                modelByte(p1);
                waitCycles($urandom_range(0, 30));
                applyStimulus(c, 1'b1);
                modelByte(c);
                waitCycles($urandom_range(0, 30));
                applyStimulus(t, 1'b1);
                modelByte(t);
                waitCycles(15);
            end
            checkOutput("rand_status", {24'd0, status}, {24'd0, m_status});
            checkOutput("rand_payload", {16'd0, payload_data}, {16'd0, m_payload});
            checkOutput("rand_err", {16'd0, err_cnt}, {16'd0, m_err});
            checkOutput("rand_fv", fv_count - fv0, m_fv);
            checkOutput("rand_busy", {31'd0, frame_busy}, {31'd0, m_busy});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx_param.md
# uart_frame_rx_param

Parametrised UART frame receiver for the DDS control path. It recovers 8N1 bytes from `uart_rxd` and assembles fixed-length frames of the form HEADER, PAYLOAD_LEN bytes, CRC8, TAIL. It checks each frame's CRC and tail and presents the payload as one flat bus with a status code. Compared with the earlier fixed 14-byte receiver, it adds:
- parametrised frame length, header/tail and CRC settings;
- start-bit glitch rejection and stop-bit framing checks;
- an inter-byte timeout;
- a saturating error counter.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz
- UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (integer division)
- PAYLOAD_LEN, 11, payload bytes per frame (1..32)
- HEADER, 8'h55, first byte of a frame
- TAIL, 8'hAA, last byte of a frame
- CRC_POLY, 8'h07, CRC8 polynomial (MSB-first, not reflected, no final XOR)
- CRC_INIT, 8'h00, CRC register value at the start of the payload
- TIMEOUT_BITS, 20, inter-byte timeout in bit periods

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset, asynchronous, active-high
- uart_rxd  in  1  serial input, idle high
- byte_data  out  8  last received byte
- byte_valid  out  1  one-cycle strobe, byte_data valid
- frame_busy  out  1  high while a frame is being assembled (after HEADER)
- payload_data  out  8*PAYLOAD_LEN  last good payload; payload byte 0 in bits [7:0]
- frame_valid  out  1  one-cycle strobe for a good frame
- status  out  8  result of the last frame or abort
- err_cnt  out  16  count of bad frames/aborts, saturates at 16'hFFFF

## Operation
Byte receiver:
- uart_rxd passes through a 2-flop synchroniser.
- A falling edge in BYTE_IDLE moves the FSM to BYTE_START.
- Bit counter runs 0..BPS_CNT-1; every bit is sampled at count BPS_CNT/2.
- BYTE_START: if the mid-bit sample is 1, the edge was a glitch; return to BYTE_IDLE with no strobe. Otherwise go to BYTE_DATA.
- BYTE_DATA: 8 bits, LSB first, then BYTE_STOP.
- BYTE_STOP: mid-stop sample 1 gives byte_valid=1 and byte_data=the byte. Mid-stop sample 0 is a framing error: no strobe, and frame_err is raised internally.
- In both cases return to BYTE_IDLE immediately, so a new start edge can be accepted during the second half of the stop bit.

Frame FSM states: HUNT, PAYLOAD, CRC, TAIL.
- HUNT: on byte_valid with HEADER, load the CRC register with CRC_INIT, clear the index, set frame_busy, go to PAYLOAD. Any other byte is discarded silently.
- PAYLOAD: each byte is stored at the current index and folded into the CRC. After PAYLOAD_LEN bytes, go to CRC. A HEADER value inside the payload is ordinary data; there is no resync.
- CRC: the received byte is compared with the computed CRC and the mismatch flag is latched. Go to TAIL.
- TAIL: if the byte != TAIL, status=8'h02. Else if the CRC mismatched, status=8'h04. Else status=8'h01, payload_data is updated and frame_valid is pulsed. Always return to HUNT and clear frame_busy.
- Timeout: in PAYLOAD, CRC or TAIL, a counter counts cycles since the last byte_valid. On reaching TIMEOUT_BITS*BPS_CNT: status=8'h03, go to HUNT.
- Framing error while outside HUNT: status=8'h05, go to HUNT. A framing error in HUNT is ignored.
- Every status other than 8'h01 increments err_cnt, saturating at 16'hFFFF.
- payload_data changes only on a good frame. A bad frame leaves the previous payload intact.

## Timing
- Reset values: byte_data=0, byte_valid=0, frame_valid=0, frame_busy=0, payload_data=0, status=8'h00, err_cnt=0. All FSMs go to IDLE/HUNT and all counters clear.
- Reset mid-frame aborts immediately. No status is written and err_cnt is unchanged.
- byte_valid asserts in the cycle after the mid-stop sample, for exactly 1 cycle.
- frame_valid, status, payload_data and the frame_busy fall all take effect 1 cycle after the TAIL byte's byte_valid.
- The CRC update takes effect 1 cycle after each payload byte_valid and is ready before the next byte can arrive.
- If the timeout terminal count and byte_valid fall in the same cycle, the byte wins: the byte is processed and the timeout counter clears.
- The timeout counter is held at 0 in HUNT.
- Sustained back-to-back frames with zero idle between bytes are supported.

## Test plan
Bench configuration: CLK_FREQ=1_000_000, UART_BPS=100_000 (BPS_CNT=10), PAYLOAD_LEN=2, TIMEOUT_BITS=20. Two frame bytes used below: CRC over payload 01,02 = 8'h1B; 8'h06 is a deliberately wrong CRC.

1. Good frame: send bytes 55 01 02 1B AA -> one frame_valid pulse, payload_data=16'h0201, status=8'h01, err_cnt=0.
2. Bad CRC: send 55 01 02 06 AA -> no frame_valid, status=8'h04, err_cnt=1, payload_data retains its previous value.
3. Bad tail, then leading garbage: send 55 01 02 1B 00 -> status=8'h02. Then send 12 34 55 01 02 1B AA -> the first two bytes are ignored and the frame is accepted, status=8'h01.
4. Timeout: send 55 01, keep the line idle for 250 cycles -> status=8'h03 at cycle 200 after the second byte_valid, frame_busy=0, err_cnt incremented.
5. Line faults: a 3-cycle low glitch on an idle line -> no byte_valid. Stop bit forced low on byte 01 inside a frame -> status=8'h05, return to HUNT.
6. Reset mid-frame: assert sys_rst_n after 55 01 -> all outputs at reset values. A following good frame is accepted normally.
